// File: rtl/aes_inv_key_sched_if.sv
// Bus between the AES-128 decryption key scheduler and its requester/consumer.
interface aes_inv_key_sched_if;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         done;

   modport master (
      output start, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_round, done
   );

   modport slave (
      input  start, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_round, done
   );
endinterface

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands forward to round 10, then streams
// round keys 10..0 by undoing one expansion step per accepted key.

module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte of the table.
   assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_inv_key_sched (
   input logic           clk,
   input logic           rst,
   aes_inv_key_sched_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXPAND = 2'd1;
   localparam logic [1:0] EMIT   = 2'd2;

   logic [1:0]   state;
   logic [127:0] key_q;
   logic [3:0]   cnt;
   logic         done_q;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p3, sel, sub, t0;
   logic [3:0]   ridx;
   logic [7:0]   rc;
   logic [127:0] fwd, inv;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // Recovered w3 of the previous round key feeds the sboxes while emitting.
   assign p3  = w3 ^ w2;
   assign sel = (state == EMIT) ? p3 : w3;

   sbox u_sb0 (.a(sel[23:16]), .y(sub[31:24]));
   sbox u_sb1 (.a(sel[15:8]),  .y(sub[23:16]));
   sbox u_sb2 (.a(sel[7:0]),   .y(sub[15:8]));
   sbox u_sb3 (.a(sel[31:24]), .y(sub[7:0]));

   assign ridx = (state == EMIT) ? (cnt - 4'd1) : cnt;

   always_comb begin
      rc = 8'h00;
      case (ridx)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
   end

   // Forward new w0 and inverse p0 share the same expression on w0.
   assign t0  = w0 ^ sub ^ {rc, 24'h000000};
   assign fwd = {t0, w1 ^ t0, w2 ^ w1 ^ t0, w3 ^ w2 ^ w1 ^ t0};
   assign inv = {t0, w1 ^ w0, w2 ^ w1, p3};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         key_q  <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  key_q <= bus.key_in;
                  cnt   <= '0;
                  state <= EXPAND;
               end
            end
            EXPAND: begin
               key_q <= fwd;
               cnt   <= cnt + 4'd1;
               if (cnt == 4'd9) state <= EMIT;
            end
            EMIT: begin
               if (bus.rk_ready) begin
                  if (cnt != 4'd0) begin
                     key_q <= inv;
                     cnt   <= cnt - 4'd1;
                  end else begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = (state == EXPAND) || (state == EMIT);
   assign bus.rk_valid = (state == EMIT);
   assign bus.rk_out   = key_q;
   assign bus.rk_round = cnt;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 expansion model built from GF(2^8) math.
module tb_aes_inv_key_sched;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_inv_key_sched_if bus ();

   aes_inv_key_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb     [0:255];
   logic [127:0] exp_rk [0:10];
   logic [127:0] obs_rk [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] x;
      logic [7:0] iv;
      for (int i = 0; i < 256; i++) begin
         x  = i[7:0];
         iv = 8'h00;
         if (x != 8'h00) begin
            iv = x;
            for (int k = 0; k < 253; k++) iv = gmul(iv, x);
         end
         sb[i] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h000000};
            rcon = rcon[7] ? ((rcon << 1) ^ 8'h1b) : (rcon << 1);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_valid"}, bus.rk_valid, 0);
      check({tag, "_done"}, bus.done, 0);
   endtask

   // One full schedule; returns early at the negedge where abort_at is on rk_round.
   task automatic run(input logic [127:0] key, input bit rnd_ready, input bit hold,
                      input bit inject, input int abort_at);
      int cyc;
      int r;
      int guard;
      model_expand(key);
      bus.key_in = key;
      bus.start  = 1'b1;
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      check("busy_on", bus.busy, 1);
      check("done_low_start", bus.done, 0);
      cyc = 1;
      while (!bus.rk_valid && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, 11);
      r = 10;
      guard = 0;
      while (r >= 0 && guard < 300) begin
         if (r == abort_at) return;
         check("round", bus.rk_round, r);
         check("key", bus.rk_out, exp_rk[r]);
         check("valid", bus.rk_valid, 1);
         check("busy", bus.busy, 1);
         obs_rk[r] = bus.rk_out;
         bus.rk_ready = rnd_ready ? ($urandom_range(1) == 1) : 1'b1;
         if (inject) begin
            bus.start  = (r == 5) || (r == 0);
            bus.key_in = SEQ_KEY;
         end
         @(negedge clk);
         guard++;
         if (bus.rk_ready) r--;
      end
      check("stream_bounded", guard < 300, 1);
      check("done_pulse", bus.done, 1);
      check("busy_off", bus.busy, 0);
      check("valid_off", bus.rk_valid, 0);
      if (inject) bus.start = 1'b0;
      if (!hold) begin
         @(negedge clk);
         check("done_one_cycle", bus.done, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      build_sbox();
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.key_in   = '0;
      bus.rk_ready = 1'b0;
      #12;
      check_idle("reset");
      check("reset_out", bus.rk_out, 0);
      check("reset_round", bus.rk_round, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      // FIPS-197 key, consumer always ready
      run(FIPS_KEY, 1'b0, 1'b0, 1'b0, -1);
      check("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("fips_r0", obs_rk[0], FIPS_KEY);

      // backpressure
      run(FIPS_KEY, 1'b1, 1'b0, 1'b0, -1);
      check("bp_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("bp_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

      // start pulses while emitting, including on the final handshake
      run(FIPS_KEY, 1'b1, 1'b0, 1'b1, -1);
      check("inj_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_idle("no_second_run");
      end

      // asynchronous reset mid-emit
      run(FIPS_KEY, 1'b0, 1'b0, 1'b0, 5);
      #2 rst = 1'b1;
      #1;
      check_idle("midrst");
      check("midrst_out", bus.rk_out, 0);
      check("midrst_round", bus.rk_round, 0);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("after_midrst");
      end
      run(SEQ_KEY, 1'b0, 1'b0, 1'b0, -1);
      check("seq_r10", obs_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // back-to-back with start held high
      run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0, -1);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1);

      // all-zero key
      run('0, 1'b0, 1'b0, 1'b0, -1);
      check("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);
      check("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // random keys under random backpressure
      for (int n = 0; n < 4; n++)
         run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
